// File: rtl/instruction_sequencer_pkg.sv
// seq_pkg: shared constants and types for the nano-processor sequencer.
//   - opcode prefixes and special opcodes
//   - destination/source register codes
//   - source_sel values and reg_en bit indices
//   - jump condition codes
//   - sequencer state enum
// Optional feature macro used by the importing files: SEQ_HALT_EN.
package seq_pkg;

  // Opcode prefixes
  localparam logic [1:0] PFX_MOVE = 2'b10;   // 10dd_dsss
  localparam logic [2:0] PFX_ALU  = 3'b110;  // 110x_yfff
  localparam logic [3:0] PFX_JUMP = 4'b1110; // 1110_cccc

  // Special opcodes
  localparam logic [7:0] OP_NOPC8 = 8'hC8;
  localparam logic [7:0] OP_NOPCF = 8'hCF;
  localparam logic [7:0] OP_NOPD8 = 8'hD8;
  localparam logic [7:0] OP_NOPDF = 8'hDF;
  localparam logic [7:0] OP_HALT  = 8'hF0;

  // Register codes (3 bits) that need special handling
  localparam logic [2:0] CODE_O_R = 3'd4; // o_reg as destination, r as source
  localparam logic [2:0] CODE_I   = 3'd6;
  localparam logic [2:0] CODE_DM  = 3'd7;

  // source_sel values beyond the direct register codes 0..7
  localparam logic [3:0] SRC_PM_DATA = 4'd8;
  localparam logic [3:0] SRC_I_PINS  = 4'd9;
  localparam logic [3:0] SRC_ZERO    = 4'd10;

  // reg_en bit indices
  localparam int EN_R     = 4;
  localparam int EN_I     = 6;
  localparam int EN_O_REG = 8;

  // Jump condition codes
  localparam logic [3:0] JC_ALWAYS = 4'b0000;
  localparam logic [3:0] JC_NZ     = 4'b0001;
  localparam logic [3:0] JC_Z      = 4'b0010;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } seq_state_e;

  // One-hot reg_en for a destination code; code 4 writes o_reg (bit 8),
  // every other code maps to its own bit.
  function automatic logic [8:0] dest_onehot(input logic [2:0] code);
    logic [8:0] en;
    if (code == CODE_O_R) en = 9'd1 << EN_O_REG;
    else                  en = 9'd1 << code;
    return en;
  endfunction

endpackage

// File: rtl/instruction_sequencer_decoder.sv
// instruction_decoder: combinational decode of the instruction register.
// Ports:
//   ir [7:0], valid    - instruction register and its valid qualifier
//   r_eq_0             - zero flag, used for conditional jumps
//   source_sel [3:0], reg_en [8:0], i_sel, x_sel, y_sel - datapath controls
//   nopc8/nopcf/nopd8/nopdf - NOP flags
//   is_jump, jump_taken, is_halt - sequencing info for the top level
// Macro SEQ_HALT_EN: when defined, 8'hF0 reports is_halt; otherwise it is a NOP.
module instruction_decoder
  import seq_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       valid,
  input  logic       r_eq_0,
  output logic [3:0] source_sel,
  output logic [8:0] reg_en,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       nopc8,
  output logic       nopcf,
  output logic       nopd8,
  output logic       nopdf,
  output logic       is_jump,
  output logic       jump_taken,
  output logic       is_halt
);

  logic [2:0] ld_dst;
  logic [2:0] mv_dst;
  logic [2:0] mv_src;
  logic [3:0] jcond;

  assign ld_dst = ir[6:4];
  assign mv_dst = ir[5:3];
  assign mv_src = ir[2:0];
  assign jcond  = ir[3:0];

  always_comb begin
    source_sel = SRC_ZERO;
    reg_en     = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    nopc8      = 1'b0;
    nopcf      = 1'b0;
    nopd8      = 1'b0;
    nopdf      = 1'b0;
    is_jump    = 1'b0;
    jump_taken = 1'b0;
    is_halt    = 1'b0;

    if (valid) begin
      if (ir[7] == 1'b0) begin
        // Load immediate
        source_sel = SRC_PM_DATA;
        reg_en     = dest_onehot(ld_dst);
        if (ld_dst == CODE_DM) begin
          reg_en[EN_I] = 1'b1;
          i_sel        = 1'b1;
        end
      end else if (ir[7:6] == PFX_MOVE) begin
        // A move onto itself reads the external i_pins instead.
        source_sel = (mv_dst == mv_src) ? SRC_I_PINS : {1'b0, mv_src};
        reg_en     = dest_onehot(mv_dst);
        if (mv_dst == CODE_DM || mv_src == CODE_DM) begin
          // dm access post-increments i, unless i is itself the target.
          reg_en[EN_I] = 1'b1;
          i_sel        = (mv_dst != CODE_I);
        end
      end else if (ir[7:5] == PFX_ALU) begin
        x_sel = ir[4];
        y_sel = ir[3];
        nopc8 = (ir == OP_NOPC8);
        nopcf = (ir == OP_NOPCF);
        nopd8 = (ir == OP_NOPD8);
        nopdf = (ir == OP_NOPDF);
        reg_en[EN_R] = !(nopc8 || nopcf || nopd8 || nopdf);
      end else if (ir[7:4] == PFX_JUMP) begin
        is_jump = 1'b1;
        case (jcond)
          JC_ALWAYS: jump_taken = 1'b1;
          JC_NZ:     jump_taken = !r_eq_0;
          JC_Z:      jump_taken = r_eq_0;
          default:   jump_taken = 1'b0;
        endcase
      end else begin
`ifdef SEQ_HALT_EN
        is_halt = (ir == OP_HALT);
`else
        is_halt = 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: program counter, instruction register and
// fetch/execute sequencing for the 4-bit nano-processor.
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   pm_data [7:0]      - program ROM data (combinational from pm_address)
//   r_eq_0             - zero flag from the computational unit
//   pm_address [7:0]   - program counter
//   nibble_ir [3:0]    - low nibble of ir
//   source_sel, reg_en, i_sel, x_sel, y_sel - decoded datapath controls
//   NOPC8, NOPCF, NOPD8, NOPDF - NOP flags
//   sync_reset         - reset registered once on clk
//   halted             - high in the HALT state
// Macro SEQ_HALT_EN: enables the HALT state entered by 8'hF0.
//
// state | meaning
// FETCH | ir invalid (after reset or a jump); fetch the next byte
// EXEC  | ir valid; controls decoded from ir, one instruction per cycle
// HALT  | frozen until reset (only reachable with SEQ_HALT_EN)
module instruction_sequencer
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pm_data,
  input  logic       r_eq_0,
  output logic [7:0] pm_address,
  output logic [3:0] nibble_ir,
  output logic [3:0] source_sel,
  output logic [8:0] reg_en,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       NOPC8,
  output logic       NOPCF,
  output logic       NOPD8,
  output logic       NOPDF,
  output logic       sync_reset,
  output logic       halted
);

  seq_state_e state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       sync_reset_q, sync_reset_d;
  logic       is_jump, jump_taken, is_halt;

  instruction_decoder u_decoder (
    .ir         (ir_q),
    .valid      (state_q == EXEC),
    .r_eq_0     (r_eq_0),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .nopc8      (NOPC8),
    .nopcf      (NOPCF),
    .nopd8      (NOPD8),
    .nopdf      (NOPDF),
    .is_jump    (is_jump),
    .jump_taken (jump_taken),
    .is_halt    (is_halt)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    sync_reset_d = reset;
    case (state_q)
      FETCH: begin
        ir_d    = pm_data;
        pc_d    = pc_q + 8'd1;
        state_d = EXEC;
      end
      EXEC: begin
        // On a jump, pm_data is the target byte; it is latched into ir
        // but discarded because FETCH treats ir as invalid.
        ir_d = pm_data;
        if (is_jump) begin
          pc_d    = jump_taken ? pm_data : pc_q + 8'd1;
          state_d = FETCH;
        end else begin
          pc_d = pc_q + 8'd1;
          if (is_halt) state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= 8'h00;
      ir_q         <= 8'h00;
      sync_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      sync_reset_q <= sync_reset_d;
    end
  end

  assign pm_address = pc_q;
  assign nibble_ir  = ir_q[3:0];
  assign sync_reset = sync_reset_q;

`ifdef SEQ_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pm_data;
  logic       r_eq_0 = 1'b0;
  logic [7:0] pm_address;
  logic [3:0] nibble_ir;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       i_sel, x_sel, y_sel;
  logic       NOPC8, NOPCF, NOPD8, NOPDF;
  logic       sync_reset, halted;

  logic [7:0] rom [0:255];
  assign pm_data = rom[pm_address];

  always #5 clk = ~clk;

  instruction_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
    .pm_address (pm_address),
    .nibble_ir  (nibble_ir),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .NOPC8      (NOPC8),
    .NOPCF      (NOPCF),
    .NOPD8      (NOPD8),
    .NOPDF      (NOPDF),
    .sync_reset (sync_reset),
    .halted     (halted)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] src;
    logic [8:0] en;
    logic       isel;
    logic       xsel;
    logic       ysel;
    logic [3:0] nops; // {C8, CF, D8, DF}
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 8'hF1;
  endtask

  // Hold reset over a couple of edges, release it at a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, " reg_en"}, 32'(reg_en), 32'h000);
    chk({name, " src"}, 32'(source_sel), 32'd10);
  endtask

  // Jump at address 3, target byte at 4, rom[target]=4A, rom[5]=05.
  task automatic run_jump(input logic [7:0] op, input logic req0, input logic taken);
    logic [7:0] tgt;
    tgt = 8'h40;
    clear_rom();
    rom[0] = 8'hD2; rom[3] = op; rom[4] = tgt; rom[5] = 8'h05; rom[tgt] = 8'h4A;
    r_eq_0 = req0;
    do_reset();
    step(); step(); step(); step();
    chk($sformatf("jmp %0h exec pc", op), 32'(pm_address), 32'h04);
    chk_idle($sformatf("jmp %0h exec", op));
    step();
    chk($sformatf("jmp %0h bubble pc", op), 32'(pm_address), taken ? 32'(tgt) : 32'h05);
    chk_idle($sformatf("jmp %0h bubble", op));
    step();
    chk($sformatf("jmp %0h next reg_en", op), 32'(reg_en), taken ? 32'h100 : 32'h001);
    chk($sformatf("jmp %0h next nib", op), 32'(nibble_ir), taken ? 32'hA : 32'h5);
    chk($sformatf("jmp %0h next pc", op), 32'(pm_address), taken ? 32'(tgt) + 1 : 32'h06);
  endtask

  initial begin
    vecs[0]  = '{8'h05, 4'd8,  9'h001, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{8'h92, 4'd9,  9'h004, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{8'hBE, 4'd6,  9'h0C0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{8'hD2, 4'd10, 9'h010, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[4]  = '{8'hC8, 4'd10, 9'h000, 1'b0, 1'b0, 1'b1, 4'b1000};
    vecs[5]  = '{8'h4A, 4'd8,  9'h100, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{8'h7C, 4'd8,  9'h0C0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{8'h8F, 4'd7,  9'h042, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{8'hB7, 4'd7,  9'h040, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{8'hA2, 4'd2,  9'h100, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[10] = '{8'hA4, 4'd9,  9'h100, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{8'hCF, 4'd10, 9'h000, 1'b0, 1'b0, 1'b1, 4'b0100};
    vecs[12] = '{8'hD8, 4'd10, 9'h000, 1'b0, 1'b1, 1'b1, 4'b0010};
    vecs[13] = '{8'hDF, 4'd10, 9'h000, 1'b0, 1'b1, 1'b1, 4'b0001};
    vecs[14] = '{8'hCB, 4'd10, 9'h010, 1'b0, 1'b0, 1'b1, 4'b0000};
    vecs[15] = '{8'hF3, 4'd10, 9'h000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[16] = '{8'h6D, 4'd8,  9'h040, 1'b0, 1'b0, 1'b0, 4'b0000};

    // Reset values
    clear_rom();
    for (int v = 0; v < NV; v++) rom[v] = vecs[v].instr;
    @(negedge clk);
    chk("rst pc", 32'(pm_address), 32'h00);
    chk("rst sync_reset", 32'(sync_reset), 32'h1);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst nibble", 32'(nibble_ir), 32'h0);
    chk_idle("rst");
    reset = 1'b0;

    // Straight-line decode table: instruction at address v executes with pc=v+1
    step();
    chk("sync_reset fall", 32'(sync_reset), 32'h0);
    for (int v = 0; v < NV; v++) begin
      if (v > 0) step();
      chk($sformatf("v%0d pc", v), 32'(pm_address), 32'(v + 1));
      chk($sformatf("v%0d src", v), 32'(source_sel), 32'(vecs[v].src));
      chk($sformatf("v%0d reg_en", v), 32'(reg_en), 32'(vecs[v].en));
      chk($sformatf("v%0d sel", v), 32'({i_sel, x_sel, y_sel}),
          32'({vecs[v].isel, vecs[v].xsel, vecs[v].ysel}));
      chk($sformatf("v%0d nops", v), 32'({NOPC8, NOPCF, NOPD8, NOPDF}), 32'(vecs[v].nops));
      chk($sformatf("v%0d nib", v), 32'(nibble_ir), 32'(vecs[v].instr[3:0]));
    end

    // Conditional / unconditional jumps
    run_jump(8'hE1, 1'b0, 1'b1);
    run_jump(8'hE1, 1'b1, 1'b0);
    run_jump(8'hE2, 1'b1, 1'b1);
    run_jump(8'hE2, 1'b0, 1'b0);
    run_jump(8'hE0, 1'b1, 1'b1);
    run_jump(8'hE7, 1'b0, 1'b0);
    run_jump(8'hE7, 1'b1, 1'b0);

    // PC wrap FF -> 00
    clear_rom();
    rom[0] = 8'hE0; rom[1] = 8'hFE;
    r_eq_0 = 1'b0;
    do_reset();
    step(); step(); step();
    chk("wrap pc FF", 32'(pm_address), 32'hFF);
    step();
    chk("wrap pc 00", 32'(pm_address), 32'h00);
    chk("wrap nop idle", 32'(reg_en), 32'h000);

    // Halt opcode
    clear_rom();
    rom[0] = 8'hF0; rom[1] = 8'h05;
    do_reset();
    step();
    chk("f0 exec pc", 32'(pm_address), 32'h01);
    chk_idle("f0 exec");
    step();
    for (int c = 0; c < 20; c++) step();
`ifdef SEQ_HALT_EN
    chk("halt halted", 32'(halted), 32'h1);
    chk("halt pc frozen", 32'(pm_address), 32'h02);
    chk_idle("halt");
    reset = 1'b1;
    #1;
    chk("halt reset pc", 32'(pm_address), 32'h00);
    chk("halt reset halted", 32'(halted), 32'h0);
`else
    chk("nohalt halted", 32'(halted), 32'h0);
    chk("nohalt pc", 32'(pm_address), 32'd22);
`endif

    // Reset in the FETCH bubble of a taken jump acts without a clock edge
    clear_rom();
    rom[3] = 8'hE0; rom[4] = 8'h40; rom[8'h40] = 8'h4A;
    do_reset();
    step(); step(); step(); step(); step();
    chk("mid pc before", 32'(pm_address), 32'h40);
    reset = 1'b1;
    #1;
    chk("mid reset pc", 32'(pm_address), 32'h00);
    chk("mid reset sync", 32'(sync_reset), 32'h1);
    chk("mid reset reg_en", 32'(reg_en), 32'h000);
    do_reset();
    step();
    chk("mid restart pc", 32'(pm_address), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
